// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common data bus: condition/exception flags and the
// registered CDB entry, plus an index-width helper used by arbiter and bus.
package cdb_arbiter_pkg;

   // Widest reservation-station id any instance may carry; instances use fewer bits.
   localparam int unsigned RS_ID_MAX = 8;

   // CR0 (lt/gt/eq/so) and XER (ov/ca) side effects travelling with a result.
   typedef struct packed {
      logic lt;
      logic gt;
      logic eq;
      logic so;
      logic ov;
      logic ca;
   } cond_exception_t;

   typedef struct packed {
      logic [RS_ID_MAX-1:0] rs_id;
      logic [0:4]           reg_addr;
      logic [0:31]          result;
      cond_exception_t      cr0_xer;
   } cdb_entry_t;

   // Width of a unit index; never below 1 bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result ports of all execution units plus the single CDB output stage.
// master: arbiter view; slave: units/consumer view.
interface cdb_arbiter_if #(
   parameter int unsigned NUM_UNITS   = 4,
   parameter int unsigned RS_ID_WIDTH = 5
);
   import cdb_arbiter_pkg::*;

   localparam int unsigned IW = idx_width(NUM_UNITS);

   logic [NUM_UNITS-1:0]                  unit_valid;
   logic [NUM_UNITS-1:0]                  unit_ready;
   logic [NUM_UNITS-1:0][RS_ID_WIDTH-1:0] unit_rs_id;
   logic [NUM_UNITS-1:0][4:0]             unit_reg_addr;
   logic [NUM_UNITS-1:0][31:0]            unit_result;
   cond_exception_t [NUM_UNITS-1:0]       unit_cr0_xer;

   logic                                  cdb_valid;
   logic                                  cdb_ready;
   logic [RS_ID_WIDTH-1:0]                cdb_rs_id;
   logic [4:0]                            cdb_reg_addr;
   logic [31:0]                           cdb_result;
   cond_exception_t                       cdb_cr0_xer;
   logic [IW-1:0]                         cdb_unit;

   modport master (
      input  unit_valid, unit_rs_id, unit_reg_addr, unit_result, unit_cr0_xer, cdb_ready,
      output unit_ready, cdb_valid, cdb_rs_id, cdb_reg_addr, cdb_result, cdb_cr0_xer, cdb_unit
   );

   modport slave (
      output unit_valid, unit_rs_id, unit_reg_addr, unit_result, unit_cr0_xer, cdb_ready,
      input  unit_ready, cdb_valid, cdb_rs_id, cdb_reg_addr, cdb_result, cdb_cr0_xer, cdb_unit
   );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins,
// wrapping from N-1 to 0. Grant is one-hot or zero.
module rr_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          enable,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);

   int unsigned pos;
   logic        found;

   // Scan N positions from ptr; wrap by explicit compare so non-power-of-two N works.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      pos       = 0;
      if (enable) begin
         for (int unsigned k = 0; k < N; k++) begin
            pos = 32'(ptr) + k;
            if (pos >= N) pos = pos - N;
            if (!found && req[pos[IW-1:0]]) begin
               found              = 1'b1;
               grant[pos[IW-1:0]] = 1'b1;
               grant_idx          = pos[IW-1:0];
            end
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin selection among execution-unit result
// ports into one full-throughput output register feeding writeback and the
// reservation-station operand update path.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_UNITS   = 4,
   parameter int unsigned RS_ID_WIDTH = 5
) (
   input logic           clk,
   input logic           rst,
   cdb_arbiter_if.master bus
);

   localparam int unsigned IW = idx_width(NUM_UNITS);

   logic                 load_en;
   logic [NUM_UNITS-1:0] grant;
   logic [IW-1:0]        grant_idx;
   logic [IW-1:0]        rr_ptr;
   logic [IW-1:0]        ptr_next;
   logic                 cdb_valid_q;
   logic [IW-1:0]        cdb_unit_q;
   cdb_entry_t           entry_q;
   cdb_entry_t           entry_d;

   // Register may take a new entry when empty or when its current one drains.
   assign load_en = !cdb_valid_q || bus.cdb_ready;

   // Arbitration is suppressed while reset is held so no unit sees ready.
   rr_arbiter #(.N(NUM_UNITS), .IW(IW)) u_rr (
      .req       (bus.unit_valid),
      .ptr       (rr_ptr),
      .enable    (load_en && rst),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign bus.unit_ready = grant;

   // Select the winner's payload and the pointer slot just after it.
   always_comb begin
      entry_d          = '0;
      entry_d.rs_id    = RS_ID_MAX'(bus.unit_rs_id[grant_idx]);
      entry_d.reg_addr = bus.unit_reg_addr[grant_idx];
      entry_d.result   = bus.unit_result[grant_idx];
      entry_d.cr0_xer  = bus.unit_cr0_xer[grant_idx];
      ptr_next         = (grant_idx == IW'(NUM_UNITS - 1)) ? '0 : grant_idx + IW'(1);
   end

   // Output stage: load on handshake, drain on accept, hold under backpressure.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cdb_valid_q <= 1'b0;
         cdb_unit_q  <= '0;
         entry_q     <= '0;
         rr_ptr      <= '0;
      end else if (load_en) begin
         if (|grant) begin
            cdb_valid_q <= 1'b1;
            cdb_unit_q  <= grant_idx;
            entry_q     <= entry_d;
            rr_ptr      <= ptr_next;
         end else begin
            cdb_valid_q <= 1'b0;
         end
      end
   end

   assign bus.cdb_valid    = cdb_valid_q;
   assign bus.cdb_unit     = cdb_unit_q;
   assign bus.cdb_rs_id    = RS_ID_WIDTH'(entry_q.rs_id);
   assign bus.cdb_reg_addr = entry_q.reg_addr;
   assign bus.cdb_result   = entry_q.result;
   assign bus.cdb_cr0_xer  = entry_q.cr0_xer;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: stimulus pushes expected CDB entries into a
// queue, an independent monitor pops and compares on every CDB handshake.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cdb_arbiter_if #(.NUM_UNITS(4), .RS_ID_WIDTH(5)) bus ();
   cdb_arbiter_if #(.NUM_UNITS(3), .RS_ID_WIDTH(5)) bus3 ();

   cdb_arbiter #(.NUM_UNITS(4), .RS_ID_WIDTH(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   cdb_arbiter #(.NUM_UNITS(3), .RS_ID_WIDTH(5)) dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3.master)
   );

   // Fixed per-unit payloads of the 4-unit instance.
   localparam logic [31:0] RES [4] = '{32'h1111_0000, 32'h2222_0001, 32'hDEAD_BEEF, 32'h4444_0003};
   localparam logic [4:0]  REG [4] = '{5'd3, 5'd4, 5'd7, 5'd9};
   localparam logic [4:0]  RSI [4] = '{5'd1, 5'd2, 5'd5, 5'd17};
   localparam logic [5:0]  CRX [4] = '{6'h01, 6'h02, 6'h04, 6'h28};

   typedef struct packed {
      logic [1:0]  unit;
      logic [4:0]  rs;
      logic [4:0]  rga;
      logic [31:0] res;
      logic [5:0]  cr;
   } exp_t;

   exp_t exp_q [$];
   int   tests = 0;
   int   fails = 0;
   int   grants [4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic push(input int u);
      exp_t e;
      e.unit = 2'(u);
      e.rs   = RSI[u];
      e.rga  = REG[u];
      e.res  = RES[u];
      e.cr   = CRX[u];
      exp_q.push_back(e);
   endtask

   // Scoreboard monitor: every accepted CDB entry must match the queue head.
   always @(negedge clk) begin
      if (rst === 1'b1 && bus.cdb_valid === 1'b1 && bus.cdb_ready === 1'b1) begin
         exp_t a;
         exp_t e;
         a = '{unit: bus.cdb_unit, rs: bus.cdb_rs_id, rga: bus.cdb_reg_addr,
               res: bus.cdb_result, cr: bus.cdb_cr0_xer};
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL cdb_unexpected: got unit=%0d res=%h, expected no entry", a.unit, a.res);
         end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
               fails++;
               $display("FAIL cdb_entry: got unit=%0d rs=%0d reg=%0d res=%h cr=%h, expected unit=%0d rs=%0d reg=%0d res=%h cr=%h",
                        a.unit, a.rs, a.rga, a.res, a.cr, e.unit, e.rs, e.rga, e.res, e.cr);
            end
         end
      end
   end

   initial begin
      rst = 1'b0;
      bus.unit_valid  = '1;
      bus.cdb_ready   = 1'b1;
      bus3.unit_valid = '0;
      bus3.cdb_ready  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.unit_result[i]   = RES[i];
         bus.unit_reg_addr[i] = REG[i];
         bus.unit_rs_id[i]    = RSI[i];
         bus.unit_cr0_xer[i]  = CRX[i];
         grants[i]            = 0;
      end
      for (int i = 0; i < 3; i++) begin
         bus3.unit_result[i]   = 32'hC0DE_0000 | 32'(i);
         bus3.unit_reg_addr[i] = 5'(i + 20);
         bus3.unit_rs_id[i]    = 5'(i + 8);
         bus3.unit_cr0_xer[i]  = '0;
      end

      // Reset held with every unit requesting.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
      chk("rst_unit_ready", 64'(bus.unit_ready), 64'd0);
      chk("rst_cdb_result", 64'(bus.cdb_result), 64'd0);
      chk("rst_cdb_unit", 64'(bus.cdb_unit), 64'd0);

      // Round robin with all four valid, consumer always ready.
      @(posedge clk); #1 rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("rr_grant", 64'(bus.unit_ready), 64'(4'b0001 << (i % 4)));
         if (i > 0) chk("rr_no_bubble", 64'(bus.cdb_valid), 64'd1);
         for (int u = 0; u < 4; u++) grants[u] += int'(bus.unit_ready[u]);
         push(i % 4);
         @(posedge clk); #1;
      end
      bus.unit_valid = '0;
      for (int u = 0; u < 4; u++) chk("rr_grant_count", 64'(grants[u]), 64'd2);

      // Single requester: unit 2.
      @(posedge clk); #1 bus.unit_valid = 4'b0100;
      @(negedge clk);
      chk("single_ready", 64'(bus.unit_ready), 64'b0100);
      push(2);
      @(posedge clk); #1 bus.unit_valid = '0;
      @(negedge clk);
      chk("single_valid", 64'(bus.cdb_valid), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("drain_valid", 64'(bus.cdb_valid), 64'd0);
      chk("drain_hold_result", 64'(bus.cdb_result), 64'hDEAD_BEEF);

      // Backpressure: units 1 and 3 valid, pointer at 3.
      @(posedge clk); #1 bus.cdb_ready = 1'b0; bus.unit_valid = 4'b1010;
      @(negedge clk);
      chk("bp_first_grant", 64'(bus.unit_ready), 64'b1000);
      push(3);
      repeat (3) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("bp_ready_low", 64'(bus.unit_ready), 64'd0);
         chk("bp_valid_held", 64'(bus.cdb_valid), 64'd1);
         chk("bp_result_held", 64'(bus.cdb_result), 64'(RES[3]));
         chk("bp_unit_held", 64'(bus.cdb_unit), 64'd3);
      end
      @(posedge clk); #1 bus.cdb_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_grant", 64'(bus.unit_ready), 64'b0010);
      push(1);
      @(posedge clk); #1 bus.unit_valid = '0;
      @(negedge clk);

      // Mid-operation asynchronous reset with a stalled entry from unit 0.
      @(posedge clk); #1 bus.cdb_ready = 1'b0; bus.unit_valid = 4'b0001;
      @(negedge clk);
      chk("mr_grant", 64'(bus.unit_ready), 64'b0001);
      @(posedge clk); #3 rst = 1'b0;
      #1;
      chk("mr_valid_drop", 64'(bus.cdb_valid), 64'd0);
      chk("mr_ready_low", 64'(bus.unit_ready), 64'd0);
      @(posedge clk); #1 rst = 1'b1; bus.cdb_ready = 1'b1;
      @(negedge clk);
      chk("mr_regrant", 64'(bus.unit_ready), 64'b0001);
      push(0);
      @(posedge clk); #1 bus.unit_valid = '0;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mr_once", 64'(bus.cdb_valid), 64'd0);

      // Three-unit instance: wrap past unit 2 and skip unit 0.
      @(posedge clk); #1 bus3.unit_valid = 3'b100;
      @(negedge clk);
      chk("w3_grant2", 64'(bus3.unit_ready), 64'b100);
      @(posedge clk); #1 bus3.unit_valid = 3'b010;
      @(negedge clk);
      chk("w3_skip0", 64'(bus3.unit_ready), 64'b010);
      chk("w3_unit2", 64'(bus3.cdb_unit), 64'd2);
      @(posedge clk); #1 bus3.unit_valid = 3'b011;
      @(negedge clk);
      chk("w3_ptr2_wrap", 64'(bus3.unit_ready), 64'b001);
      chk("w3_unit1", 64'(bus3.cdb_unit), 64'd1);
      chk("w3_result1", 64'(bus3.cdb_result), 64'hC0DE_0001);
      @(posedge clk); #1 bus3.unit_valid = '0;
      @(negedge clk);
      chk("w3_unit0", 64'(bus3.cdb_unit), 64'd0);

      @(posedge clk); #1;
      chk("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
